text_line_sequencer: RTL and testbench
======================================

Name: text_line_sequencer

Overview:
- Upstream feeder for the glyph renderer: holds a one-line string of 5-bit letter codes and, per pixel, tells the renderer which letter to draw and where.
- Loads the string through a valid/ready write port and tracks character cells from hcount/vcount with counters, so no divider is needed.
- Emits a registered letter code plus the glyph origin, and a delayed copy of hcount/vcount, all on the same cycle.
- Sits between game/control logic and the font renderer in the video pipeline.

Parameters:
- MAX_CHARS, 16, buffer depth in characters; index width is $clog2(MAX_CHARS).
- X_POS, 128, left pixel of character 0.
- Y_POS, 128, top pixel of the text row.
- REVEAL_FRAMES, 4, frames per newly revealed character. Used only with TYPEWRITER_EN.

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous, active-high reset
- hcount_in  in  11  current pixel column; increments by 1 per clock within a line
- vcount_in  in  10  current pixel row
- new_frame_in  in  1  one-cycle pulse at frame start
- scale_in  in  4  glyph scale exponent; values >5 are treated as 5
- wr_valid_in  in  1  write character valid
- wr_char_in  in  5  letter code (0 = blank)
- wr_last_in  in  1  final character of the string
- wr_ready_out  out  1  buffer accepts a write this cycle
- clear_in  in  1  discard the string and return to EMPTY
- letter_out  out  5  letter to draw at hcount_out (0 = nothing)
- glyph_x_out  out  11  X origin of the current cell
- glyph_y_out  out  10  Y origin of the row (= Y_POS)
- hcount_out  out  11  hcount_in delayed 1 cycle
- vcount_out  out  10  vcount_in delayed 1 cycle
- busy_out  out  1  high while LOADING

Behaviour:
- Reset (async, rst_in=1): all outputs 0; state EMPTY; length=0; wr_ptr=0; scale_q=0; reveal=0.
- States:
  - EMPTY: wr_ready=1. An accepted write goes to LOADING, or straight to SHOW if wr_last_in=1.
  - LOADING: wr_ready=1, busy=1. On an accepted write with wr_last_in=1, or when the write fills slot MAX_CHARS-1 (forced last), go to SHOW.
  - SHOW: wr_ready=0; writes are ignored.
- Write and length:
  - A write is accepted when wr_valid_in & wr_ready_out: buf[wr_ptr]<=wr_char_in; wr_ptr++; length<=wr_ptr+1.
- clear_in, from any state:
  - Next cycle: state=EMPTY, wr_ptr=0, length=0, reveal=0.
  - clear_in wins over a simultaneous write, and the write is dropped.
  - Buffer contents need not be cleared.
- scale_q: sampled from min(scale_in,5) on new_frame_in only, so there is no mid-frame change.
- Cell width: cell_w = 12<<scale_q, 12..384.
- Row hit: vcount_in in [Y_POS, Y_POS+cell_w-1].
- Cell tracking: pixel X_POS + k*cell_w + j, with 0<=j<cell_w and k<length, maps to index k.
  - Implemented with a sub-pixel counter and an index counter, restarted at hcount_in==X_POS.
  - glyph_x accumulates by cell_w per cell.
- Latency: 1 cycle. letter_out, glyph_x_out, glyph_y_out, hcount_out and vcount_out all describe pixel hcount_in of the previous cycle.
- letter_out=buf[k] when all of the following hold; otherwise letter_out=0, glyph_x_out=0, glyph_y_out=0:
  - row hit;
  - hcount_in >= X_POS;
  - k < length;
  - k < visible (visible=length without TYPEWRITER_EN).
- Boundaries:
  - length=0 means letter_out is always 0.
  - hcount wrap at line end restarts tracking at the next X_POS.
  - A cell that extends past the screen edge is simply truncated.
  - A string loaded mid-frame becomes visible on the next line containing X_POS.

Optional Feature:
- Macro TEXT_TYPEWRITER_EN, defined:
  - A frame counter counts new_frame_in pulses while in SHOW.
  - Every REVEAL_FRAMES pulses, reveal++ until reveal==length; visible=reveal.
  - Entering SHOW sets reveal=0; clear_in resets it.
- Not defined: visible=length immediately; no counter logic is instantiated.

Decomposition:
- Package text_pkg:
  - LETTER_W=5, GLYPH_BASE=12, MAX_SCALE=5;
  - typedef letter_t (logic[4:0]);
  - enum seq_state_t {EMPTY, LOADING, SHOW}.
- Sub-module text_char_buf: MAX_CHARS x 5 register file with one write port and one async read port.

Test Plan:
- Write 3 chars {1,2,3}, wr_last on the third, scale_in=0, new_frame_in pulse:
  - on row vcount=128, hcount 128..139 gives letter_out=1 with glyph_x=128;
  - hcount 140..151 gives 2 with glyph_x=140; 152..163 gives 3; 164 gives 0;
  - all values appear 1 cycle later on hcount_out.
- scale_in=1: cell_w=24; hcount 152 gives letter 1→2 boundary, glyph_x=152; vcount=151 hits the row, 152 does not.
- Write 16 chars without wr_last: state SHOW after the 16th; wr_ready_out=0; a 17th write is ignored and length=16.
- clear_in and wr_valid_in asserted in the same cycle during LOADING: EMPTY next cycle, length=0, letter_out=0 on every pixel.
- rst_in pulsed mid-line during SHOW: outputs 0 asynchronously; after release wr_ready_out=1 and nothing is drawn.
- With TEXT_TYPEWRITER_EN and REVEAL_FRAMES=2, after loading {4,5}:
  - frames 0-1 show nothing;
  - frames 2-3 show only letter 4;
  - frame 4 onward shows both.

Source files
------------

// File: rtl/text_line_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared types and constants for the text line sequencer:
//   LETTER_W   - width of a letter code (0 = blank)
//   GLYPH_BASE - unscaled glyph cell width in pixels
//   MAX_SCALE  - largest glyph scale exponent honoured
//   letter_t   - letter code type
//   seq_state_t- load/display state of the string buffer
// -----------------------------------------------------------------------------
package text_pkg;

  localparam int LETTER_W   = 5;
  localparam int GLYPH_BASE = 12;
  localparam int MAX_SCALE  = 5;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    SHOW    = 2'd2
  } seq_state_t;

  // Scale exponents above MAX_SCALE are treated as MAX_SCALE.
  function automatic logic [2:0] clamp_scale(input logic [3:0] s);
    return (s > 4'(MAX_SCALE)) ? 3'(MAX_SCALE) : s[2:0];
  endfunction

  // Cell width in pixels: 12 << scale, 12..384.
  function automatic logic [8:0] cell_width(input logic [2:0] scale);
    return 9'(GLYPH_BASE) << scale;
  endfunction

endpackage

// File: rtl/text_line_sequencer_char_buf.sv
// -----------------------------------------------------------------------------
// text_char_buf
// DEPTH x LETTER_W register file holding the string. One synchronous write
// port, one asynchronous read port. Contents are not reset.
// Ports:
//   clk_in      - pixel clock
//   wr_en_in    - write strobe
//   wr_idx_in   - write slot
//   wr_data_in  - letter code to store
//   rd_idx_in   - read slot
//   rd_data_out - letter code at rd_idx_in (combinational)
// -----------------------------------------------------------------------------
module text_char_buf
  import text_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_in,
  input  logic             wr_en_in,
  input  logic [IDX_W-1:0] wr_idx_in,
  input  letter_t          wr_data_in,
  input  logic [IDX_W-1:0] rd_idx_in,
  output letter_t          rd_data_out
);

  letter_t mem_q [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_q[wr_idx_in] <= wr_data_in;
    end
  end

  assign rd_data_out = mem_q[rd_idx_in];

endmodule

// File: rtl/text_line_sequencer.sv
// -----------------------------------------------------------------------------
// text_line_sequencer
// Holds a one-line string of letter codes and, for every pixel, tells the glyph
// renderer which letter to draw and the origin of its cell. Cell position is
// tracked with a sub-pixel counter and an index counter restarted at X_POS, so
// no divider is needed. All pixel outputs have one cycle of latency and are
// aligned with hcount_out/vcount_out.
//
// Optional build macro: TEXT_TYPEWRITER_EN
//   defined   - characters are revealed one at a time, one every REVEAL_FRAMES
//               frame pulses while in SHOW.
//   undefined - the whole loaded string is visible at once.
//
// Ports:
//   clk_in, rst_in          - pixel clock, asynchronous active-high reset
//   hcount_in, vcount_in    - current pixel position
//   new_frame_in            - frame-start pulse (latches scale, paces reveal)
//   scale_in                - glyph scale exponent (clamped to 5)
//   wr_valid_in/wr_char_in/wr_last_in, wr_ready_out - string write port
//   clear_in                - discard the string
//   letter_out, glyph_x_out, glyph_y_out - letter and cell origin
//   hcount_out, vcount_out  - pixel position delayed to match
//   busy_out                - string is being loaded
// -----------------------------------------------------------------------------
module text_line_sequencer
  import text_pkg::*;
#(
  parameter int MAX_CHARS     = 16,
  parameter int X_POS         = 128,
  parameter int Y_POS         = 128,
  parameter int REVEAL_FRAMES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic [3:0]  scale_in,
  input  logic        wr_valid_in,
  input  logic [4:0]  wr_char_in,
  input  logic        wr_last_in,
  output logic        wr_ready_out,
  input  logic        clear_in,
  output logic [4:0]  letter_out,
  output logic [10:0] glyph_x_out,
  output logic [9:0]  glyph_y_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        busy_out
);

  localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int LEN_W = $clog2(MAX_CHARS + 1);

  if (MAX_CHARS < 1 || REVEAL_FRAMES < 1) begin : g_param_check
    $error("text_line_sequencer: MAX_CHARS and REVEAL_FRAMES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Load control
  // ---------------------------------------------------------------------------
  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic             wr_ready_q, wr_ready_d;
  logic             busy_q, busy_d;
  logic             wr_accept;
  logic             entering_show;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    length_d  = length_q;
    wr_accept = 1'b0;
    if (clear_in) begin
      // clear wins over a simultaneous write; the write is dropped
      state_d  = EMPTY;
      wr_ptr_d = '0;
      length_d = '0;
    end else if (wr_valid_in && wr_ready_q) begin
      wr_accept = 1'b1;
      wr_ptr_d  = wr_ptr_q + IDX_W'(1);
      length_d  = LEN_W'(wr_ptr_q) + LEN_W'(1);
      if (wr_last_in || (wr_ptr_q == IDX_W'(MAX_CHARS - 1))) begin
        state_d = SHOW;
      end else begin
        state_d = LOADING;
      end
    end
    // ready/busy are registered copies of the next state so they read 0
    // during reset and follow the state from the first clock after it.
    wr_ready_d    = (state_d != SHOW);
    busy_d        = (state_d == LOADING);
    entering_show = (state_d == SHOW) && (state_q != SHOW);
  end

  // ---------------------------------------------------------------------------
  // Character storage
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] cur_idx;
  letter_t          rd_letter;

  text_char_buf #(
    .DEPTH (MAX_CHARS),
    .IDX_W (IDX_W)
  ) u_char_buf (
    .clk_in      (clk_in),
    .wr_en_in    (wr_accept),
    .wr_idx_in   (wr_ptr_q),
    .wr_data_in  (wr_char_in),
    .rd_idx_in   (cur_idx[IDX_W-1:0]),
    .rd_data_out (rd_letter)
  );

  // ---------------------------------------------------------------------------
  // Scale, latched once per frame
  // ---------------------------------------------------------------------------
  logic [2:0] scale_q, scale_d;
  logic [8:0] cell_w;

  always_comb begin
    scale_d = new_frame_in ? clamp_scale(scale_in) : scale_q;
    cell_w  = cell_width(scale_q);
  end

  // ---------------------------------------------------------------------------
  // Visible character count
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] visible;

`ifdef TEXT_TYPEWRITER_EN
  localparam int FC_W = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;

  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [LEN_W-1:0] reveal_q, reveal_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    reveal_d    = reveal_q;
    if (clear_in || entering_show) begin
      frame_cnt_d = '0;
      reveal_d    = '0;
    end else if ((state_q == SHOW) && new_frame_in) begin
      if (frame_cnt_q == FC_W'(REVEAL_FRAMES - 1)) begin
        frame_cnt_d = '0;
        if (reveal_q < length_q) begin
          reveal_d = reveal_q + LEN_W'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_cnt_q <= '0;
      reveal_q    <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      reveal_q    <= reveal_d;
    end
  end

  assign visible = reveal_q;
`else
  assign visible = length_q;
`endif

  // ---------------------------------------------------------------------------
  // Cell tracking
  // ---------------------------------------------------------------------------
  // sub_q/idx_q/gx_q hold the position of the pixel expected on the next
  // cycle; at hcount_in == X_POS they are overridden so every line restarts
  // cleanly regardless of where the previous one ended.
  logic [8:0]       sub_q, sub_d, cur_sub;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [10:0]      gx_q, gx_d, cur_gx;
  // Visible count captured at the start of the line: a string that appears
  // mid-line waits for the next line that passes X_POS.
  logic [LEN_W-1:0] line_vis_q, line_vis_d, vis_lim;
  logic             at_origin, row_hit, col_hit, pix_hit;

  always_comb begin
    at_origin = (hcount_in == 11'(X_POS));
    if (at_origin) begin
      cur_sub    = '0;
      cur_idx    = '0;
      cur_gx     = 11'(X_POS);
      vis_lim    = visible;
      line_vis_d = visible;
    end else begin
      cur_sub    = sub_q;
      cur_idx    = idx_q;
      cur_gx     = gx_q;
      vis_lim    = (line_vis_q < visible) ? line_vis_q : visible;
      line_vis_d = line_vis_q;
    end
    if (clear_in) begin
      line_vis_d = '0;
    end

    if (cur_sub == (cell_w - 9'd1)) begin
      sub_d = '0;
      // saturate once past the last possible slot
      idx_d = (cur_idx == LEN_W'(MAX_CHARS)) ? cur_idx : cur_idx + LEN_W'(1);
      gx_d  = cur_gx + {2'b00, cell_w};
    end else begin
      sub_d = cur_sub + 9'd1;
      idx_d = cur_idx;
      gx_d  = cur_gx;
    end

    row_hit = ({1'b0, vcount_in} >= 11'(Y_POS)) &&
              ({1'b0, vcount_in} < (11'(Y_POS) + {2'b00, cell_w}));
    col_hit = (hcount_in >= 11'(X_POS));
    pix_hit = row_hit && col_hit && (cur_idx < vis_lim);
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [4:0]  letter_q, letter_d;
  logic [10:0] glyph_x_q, glyph_x_d;
  logic [9:0]  glyph_y_q, glyph_y_d;
  logic [10:0] hcount_q;
  logic [9:0]  vcount_q;

  always_comb begin
    letter_d  = '0;
    glyph_x_d = '0;
    glyph_y_d = '0;
    if (pix_hit) begin
      letter_d  = rd_letter;
      glyph_x_d = cur_gx;
      glyph_y_d = 10'(Y_POS);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= '0;
      length_q   <= '0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      scale_q    <= '0;
      sub_q      <= '0;
      idx_q      <= '0;
      gx_q       <= '0;
      line_vis_q <= '0;
      letter_q   <= '0;
      glyph_x_q  <= '0;
      glyph_y_q  <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      length_q   <= length_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      scale_q    <= scale_d;
      sub_q      <= sub_d;
      idx_q      <= idx_d;
      gx_q       <= gx_d;
      line_vis_q <= line_vis_d;
      letter_q   <= letter_d;
      glyph_x_q  <= glyph_x_d;
      glyph_y_q  <= glyph_y_d;
      hcount_q   <= hcount_in;
      vcount_q   <= vcount_in;
    end
  end

  assign wr_ready_out = wr_ready_q;
  assign busy_out     = busy_q;
  assign letter_out   = letter_q;
  assign glyph_x_out  = glyph_x_q;
  assign glyph_y_out  = glyph_y_q;
  assign hcount_out   = hcount_q;
  assign vcount_out   = vcount_q;

endmodule

// File: tb/tb_text_line_sequencer.sv
module tb_text_line_sequencer;

  localparam int MAXC = 16;
  localparam int XP   = 128;
  localparam int YP   = 128;
  localparam int RF   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        nf;
  logic [3:0]  sc;
  logic        wv;
  logic [4:0]  wc;
  logic        wl;
  logic        clr;
  logic        wr_ready;
  logic [4:0]  letter;
  logic [10:0] gx;
  logic [9:0]  gy;
  logic [10:0] hout;
  logic [9:0]  vout;
  logic        busy;

  always #5 clk = ~clk;

  text_line_sequencer #(
    .MAX_CHARS(MAXC), .X_POS(XP), .Y_POS(YP), .REVEAL_FRAMES(RF)
  ) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .new_frame_in(nf), .scale_in(sc), .wr_valid_in(wv), .wr_char_in(wc),
    .wr_last_in(wl), .wr_ready_out(wr_ready), .clear_in(clr),
    .letter_out(letter), .glyph_x_out(gx), .glyph_y_out(gy),
    .hcount_out(hout), .vcount_out(vout), .busy_out(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: the string as a list, a shown flag, a frame-pulse
  // count, and the visible count seen when the line last passed X_POS.
  int m_buf[MAXC];
  int m_len, m_pulses, m_scale, m_line_vis;
  bit m_show, m_ready;
  int e_letter, e_gx, e_gy, e_h, e_v;
  int got_l[2048];
  int got_gx[2048];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int m_visible();
`ifdef TEXT_TYPEWRITER_EN
    return ((m_pulses / RF) < m_len) ? (m_pulses / RF) : m_len;
`else
    return m_len;
`endif
  endfunction

  task automatic model_reset();
    m_len = 0; m_pulses = 0; m_scale = 0; m_line_vis = 0;
    m_show = 0; m_ready = 0;
    e_letter = 0; e_gx = 0; e_gy = 0; e_h = 0; e_v = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_letter"}, letter, e_letter);
    chk({tag, "_glyph_x"}, gx, e_gx);
    chk({tag, "_glyph_y"}, gy, e_gy);
    chk({tag, "_hcount_out"}, hout, e_h);
    chk({tag, "_vcount_out"}, vout, e_v);
    chk({tag, "_wr_ready"}, wr_ready, int'(m_ready));
    chk({tag, "_busy"}, busy, int'(!m_show && m_len > 0));
  endtask

  // One clock: predict outputs for the sampled pixel, advance the model,
  // then compare after the edge.
  task automatic step();
    int cw, lim, k, vnow, in_h, in_v;
    @(posedge clk);
    in_h = int'(hc);
    in_v = int'(vc);
    cw   = 12 << m_scale;
    vnow = m_visible();
    lim  = (in_h == XP) ? vnow : ((m_line_vis < vnow) ? m_line_vis : vnow);
    k    = (in_h >= XP) ? (in_h - XP) / cw : 0;
    if (in_v >= YP && in_v < YP + cw && in_h >= XP && k < lim) begin
      e_letter = m_buf[k]; e_gx = XP + k * cw; e_gy = YP;
    end else begin
      e_letter = 0; e_gx = 0; e_gy = 0;
    end
    e_h = in_h; e_v = in_v;
    if (in_h == XP) m_line_vis = vnow;
    if (nf) begin
      m_scale = (sc > 5) ? 5 : int'(sc);
      if (m_show) m_pulses++;
    end
    if (clr) begin
      m_len = 0; m_show = 0; m_pulses = 0; m_line_vis = 0;
    end else if (wv && m_ready) begin
      m_buf[m_len] = int'(wc);
      m_len++;
      if (wl || m_len == MAXC) begin m_show = 1; m_pulses = 0; end
    end
    m_ready = !m_show;
    #1;
    check_outputs("cyc");
    got_l[in_h]  = int'(letter);
    got_gx[in_h] = int'(gx);
  endtask

  task automatic write_char(input int c, input bit last);
    wv = 1'b1; wc = 5'(c); wl = last;
    step();
    wv = 1'b0; wl = 1'b0;
  endtask

  task automatic frame(input int s);
    nf = 1'b1; sc = 4'(s); hc = '0; vc = '0;
    step();
    nf = 1'b0;
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int i = 0; i < 2048; i++) begin got_l[i] = -1; got_gx[i] = -1; end
    vc = 10'(v);
    for (int h = h0; h <= h1; h++) begin
      hc = 11'(h);
      step();
    end
  endtask

  task automatic pin(input string name, input int h, input int exp_l, input int exp_gx);
    chk({name, "_letter"}, got_l[h], exp_l);
    chk({name, "_glyph_x"}, got_gx[h], exp_gx);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    chk({tag, "_letter"}, letter, 0);
    chk({tag, "_glyph_x"}, gx, 0);
    chk({tag, "_glyph_y"}, gy, 0);
    chk({tag, "_hcount_out"}, hout, 0);
    chk({tag, "_vcount_out"}, vout, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    hc = '0; vc = '0; nf = 0; sc = '0; wv = 0; wc = '0; wl = 0; clr = 0;
    rst = 1'b0;
    #3;
    async_reset_check("reset");
    step();
    chk("ready_after_reset", wr_ready, 1);

    // String {1,2,3} at scale 0
    frame(0);
    write_char(1, 0);
    chk("busy_loading", busy, 1);
    write_char(2, 0);
    write_char(3, 1);
    chk("ready_in_show", wr_ready, 0);
    line(128, 120, 170);
    pin("s0_h127", 127, 0, 0);
    pin("s0_h128", 128, 1, 128);
    pin("s0_h139", 139, 1, 128);
    pin("s0_h140", 140, 2, 140);
    pin("s0_h151", 151, 2, 140);
    pin("s0_h152", 152, 3, 152);
    pin("s0_h163", 163, 3, 152);
    pin("s0_h164", 164, 0, 0);
    line(139, 120, 140);
    pin("s0_v139", 128, 1, 128);
    line(140, 120, 140);
    pin("s0_v140", 128, 0, 0);

    // Scale 1: 24-pixel cells
    frame(1);
    line(128, 120, 210);
    pin("s1_h151", 151, 1, 128);
    pin("s1_h152", 152, 2, 152);
    pin("s1_h176", 176, 3, 176);
    pin("s1_h200", 200, 0, 0);
    line(151, 120, 160);
    pin("s1_v151", 152, 2, 152);
    line(152, 120, 160);
    pin("s1_v152", 152, 0, 0);

    // Scale request above 5 is clamped to 384-pixel cells
    frame(9);
    line(400, 120, 140);
    pin("s9_h140", 140, 1, 128);

    // Clear, then 16 characters without wr_last
    clr = 1'b1; step(); clr = 1'b0;
    chk("ready_after_clear", wr_ready, 1);
    frame(0);
    for (int i = 0; i < MAXC; i++) write_char(i + 1, 0);
    chk("ready_full", wr_ready, 0);
    write_char(31, 0);
    line(128, 120, 330);
    pin("full_last", 128 + 15 * 12, 16, 128 + 15 * 12);
    pin("full_past", 128 + 16 * 12, 0, 0);

    // Clear with a simultaneous write during LOADING
    clr = 1'b1; step(); clr = 1'b0;
    write_char(7, 0);
    chk("busy_before_clear", busy, 1);
    clr = 1'b1; wv = 1'b1; wc = 5'd8; step(); clr = 1'b0; wv = 1'b0;
    chk("clear_wins_ready", wr_ready, 1);
    chk("clear_wins_busy", busy, 0);
    line(128, 120, 170);
    pin("clear_h128", 128, 0, 0);
    pin("clear_h140", 140, 0, 0);

    // Load mid-line: invisible until the next line passes X_POS
    vc = 10'd128;
    for (int h = 120; h <= 150; h++) begin
      hc = 11'(h);
      if (h == 130) begin wv = 1'b1; wc = 5'd9; wl = 1'b1; end
      step();
      wv = 1'b0; wl = 1'b0;
      if (h == 145) chk("midline_hidden", letter, 0);
    end
    line(128, 120, 150);
    pin("midline_next", 130, 9, 128);

    // Async reset mid-line during SHOW
    vc = 10'd128;
    for (int h = 120; h <= 133; h++) begin hc = 11'(h); step(); end
    chk("pre_reset_letter", letter, 9);
    async_reset_check("midreset");
    step();
    chk("ready_after_midreset", wr_ready, 1);
    line(128, 120, 170);
    pin("after_reset_h130", 130, 0, 0);

`ifdef TEXT_TYPEWRITER_EN
    frame(0);
    write_char(4, 0);
    write_char(5, 1);
    for (int f = 0; f < 6; f++) begin
      line(128, 120, 160);
      pin($sformatf("tw_f%0d_c0", f), 130, (f < 2) ? 0 : 4, (f < 2) ? 0 : 128);
      pin($sformatf("tw_f%0d_c1", f), 142, (f < 4) ? 0 : 5, (f < 4) ? 0 : 140);
      frame(0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
